// File: rtl/mem_arbiter_if.sv
// One cache-style memory channel: request, write-data and read-response paths.
// The requester side uses the master modport; the side that serves requests uses slave.
interface mem_arbiter_if #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_BITS-1:0]   req_addr;
    logic                   req_rw;
    logic                   req_data_valid;
    logic                   req_data_ready;
    logic [DATA_BITS-1:0]   req_data_bits;
    logic [DATA_BITS/8-1:0] req_data_mask;
    logic                   resp_valid;
    logic [DATA_BITS-1:0]   resp_data;

    modport master (
        output req_valid, req_addr, req_rw,
        output req_data_valid, req_data_bits, req_data_mask,
        input  req_ready, req_data_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_rw,
        input  req_data_valid, req_data_bits, req_data_mask,
        output req_ready, req_data_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache memory channels onto one memory port, one
// transaction outstanding at a time, round-robin under contention.
module mem_arbiter #(
    parameter int ADDR_BITS  = 28,
    parameter int DATA_BITS  = 128,
    parameter int READ_BEATS = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  ic,
    mem_arbiter_if.slave  dc,
    mem_arbiter_if.master mem
);
    localparam int CNT_BITS = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(READ_BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    typedef enum logic {CL_IC = 1'b0, CL_DC = 1'b1} client_t;

    state_t              state, state_next;
    client_t             owner, owner_next;
    client_t             rr_last, rr_last_next;
    client_t             grant;
    logic [CNT_BITS-1:0] count, count_next;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= CL_IC;
            rr_last <= CL_IC;
            count   <= '0;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            rr_last <= rr_last_next;
            count   <= count_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        owner_next   = owner;
        rr_last_next = rr_last;
        count_next   = count;
        grant        = CL_IC;

        mem.req_valid      = 1'b0;
        mem.req_addr       = '0;
        mem.req_rw         = 1'b0;
        mem.req_data_valid = 1'b0;
        mem.req_data_bits  = '0;
        mem.req_data_mask  = '0;
        ic.req_ready       = 1'b0;
        ic.req_data_ready  = 1'b0;
        ic.resp_valid      = 1'b0;
        ic.resp_data       = mem.resp_data;
        dc.req_ready       = 1'b0;
        dc.req_data_ready  = 1'b0;
        dc.resp_valid      = 1'b0;
        dc.resp_data       = mem.resp_data;

        case (state)
            IDLE: begin
                if (ic.req_valid && dc.req_valid)
                    grant = (rr_last == CL_IC) ? CL_DC : CL_IC;
                else if (dc.req_valid)
                    grant = CL_DC;

                mem.req_valid = ic.req_valid || dc.req_valid;
                if (grant == CL_DC) begin
                    mem.req_addr = dc.req_addr;
                    mem.req_rw   = dc.req_rw;
                    dc.req_ready = mem.req_valid && mem.req_ready;
                end else begin
                    mem.req_addr = ic.req_addr;
                    mem.req_rw   = ic.req_rw;
                    ic.req_ready = mem.req_valid && mem.req_ready;
                end

                if (mem.req_valid && mem.req_ready) begin
                    owner_next   = grant;
                    rr_last_next = grant;
                    count_next   = '0;
                    state_next   = mem.req_rw ? WRITE : READ;
                end
            end

            READ: begin
                if (owner == CL_DC) dc.resp_valid = mem.resp_valid;
                else                ic.resp_valid = mem.resp_valid;

                if (mem.resp_valid) begin
                    if (count == LAST_BEAT) begin
                        count_next = '0;
                        state_next = IDLE;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
            end

            WRITE: begin
                if (owner == CL_DC) begin
                    mem.req_data_valid = dc.req_data_valid;
                    mem.req_data_bits  = dc.req_data_bits;
                    mem.req_data_mask  = dc.req_data_mask;
                    dc.req_data_ready  = mem.req_data_ready;
                end else begin
                    mem.req_data_valid = ic.req_data_valid;
                    mem.req_data_bits  = ic.req_data_bits;
                    mem.req_data_mask  = ic.req_data_mask;
                    ic.req_data_ready  = mem.req_data_ready;
                end
                if (mem.req_data_valid && mem.req_data_ready)
                    state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase

        // Outputs are held quiet for the whole reset pulse, not just after the next edge.
        if (reset) begin
            mem.req_valid      = 1'b0;
            mem.req_addr       = '0;
            mem.req_rw         = 1'b0;
            mem.req_data_valid = 1'b0;
            mem.req_data_bits  = '0;
            mem.req_data_mask  = '0;
            ic.req_ready       = 1'b0;
            ic.req_data_ready  = 1'b0;
            ic.resp_valid      = 1'b0;
            ic.resp_data       = '0;
            dc.req_ready       = 1'b0;
            dc.req_data_ready  = 1'b0;
            dc.resp_valid      = 1'b0;
            dc.resp_data       = '0;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are sampled around the
// falling edge, so every check sees settled values between rising edges.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    mem_arbiter_if #(.ADDR_BITS(28), .DATA_BITS(128)) ic_bus ();
    mem_arbiter_if #(.ADDR_BITS(28), .DATA_BITS(128)) dc_bus ();
    mem_arbiter_if #(.ADDR_BITS(28), .DATA_BITS(128)) mem_bus ();

    mem_arbiter #(.ADDR_BITS(28), .DATA_BITS(128), .READ_BEATS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .ic    (ic_bus),
        .dc    (dc_bus),
        .mem   (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present an IDLE request and check it is forwarded and granted to the expected client.
    task automatic expect_grant(input logic to_dc, input logic [27:0] addr, input logic rw, input string tag);
        #1;
        check({tag, "_mvalid"}, 128'(mem_bus.req_valid), 128'(1));
        check({tag, "_maddr"},  128'(mem_bus.req_addr),  128'(addr));
        check({tag, "_mrw"},    128'(mem_bus.req_rw),    128'(rw));
        check({tag, "_dc_rdy"}, 128'(dc_bus.req_ready),  128'(to_dc));
        check({tag, "_ic_rdy"}, 128'(ic_bus.req_ready),  128'(!to_dc));
    endtask

    // Four response beats data base..base+3; an optional idle cycle is inserted before beat gap_at.
    task automatic do_read(input logic to_dc, input logic [127:0] base, input int gap_at, input string tag);
        for (int b = 0; b < 4; b++) begin
            if (b == gap_at) begin
                mem_bus.resp_valid = 1'b0;
                #1;
                check($sformatf("%s_gap_dc", tag), 128'(dc_bus.resp_valid), 128'(0));
                check($sformatf("%s_gap_ic", tag), 128'(ic_bus.resp_valid), 128'(0));
                tick();
            end
            mem_bus.resp_valid = 1'b1;
            mem_bus.resp_data  = base + 128'(b);
            #1;
            check($sformatf("%s_b%0d_dcv", tag, b), 128'(dc_bus.resp_valid), 128'(to_dc));
            check($sformatf("%s_b%0d_icv", tag, b), 128'(ic_bus.resp_valid), 128'(!to_dc));
            check($sformatf("%s_b%0d_dcd", tag, b), dc_bus.resp_data, base + 128'(b));
            check($sformatf("%s_b%0d_icd", tag, b), ic_bus.resp_data, base + 128'(b));
            check($sformatf("%s_b%0d_mvalid", tag, b), 128'(mem_bus.req_valid), 128'(0));
            check($sformatf("%s_b%0d_rdy", tag, b), 128'(ic_bus.req_ready | dc_bus.req_ready), 128'(0));
            tick();
        end
        mem_bus.resp_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ic_bus.req_valid = 0; ic_bus.req_addr = '0; ic_bus.req_rw = 0;
        ic_bus.req_data_valid = 0; ic_bus.req_data_bits = '0; ic_bus.req_data_mask = '0;
        dc_bus.req_valid = 0; dc_bus.req_addr = '0; dc_bus.req_rw = 0;
        dc_bus.req_data_valid = 0; dc_bus.req_data_bits = '0; dc_bus.req_data_mask = '0;
        mem_bus.req_ready = 0; mem_bus.req_data_ready = 0;
        mem_bus.resp_valid = 0; mem_bus.resp_data = '0;

        // Outputs quiet while reset is high, even with active inputs.
        @(negedge clk);
        ic_bus.req_valid = 1; ic_bus.req_data_valid = 1; mem_bus.req_ready = 1;
        mem_bus.req_data_ready = 1; mem_bus.resp_valid = 1; mem_bus.resp_data = 128'h55;
        #1;
        check("rst_mvalid", 128'(mem_bus.req_valid), 128'(0));
        check("rst_mdvalid", 128'(mem_bus.req_data_valid), 128'(0));
        check("rst_ic_rdy", 128'(ic_bus.req_ready), 128'(0));
        check("rst_ic_resp", 128'(ic_bus.resp_valid), 128'(0));
        check("rst_ic_data", ic_bus.resp_data, 128'(0));
        check("rst_dc_resp", 128'(dc_bus.resp_valid), 128'(0));
        ic_bus.req_valid = 0; ic_bus.req_data_valid = 0; mem_bus.req_data_ready = 0;
        mem_bus.resp_valid = 0; mem_bus.resp_data = '0;
        tick();

        // Both clients read in the first cycle after reset: dc first, then ic.
        reset = 0;
        ic_bus.req_valid = 1; ic_bus.req_addr = 28'h0000200; ic_bus.req_rw = 0;
        dc_bus.req_valid = 1; dc_bus.req_addr = 28'h0000300; dc_bus.req_rw = 0;
        expect_grant(1'b1, 28'h0000300, 1'b0, "both_dc");
        tick();
        dc_bus.req_valid = 0;
        do_read(1'b1, 128'h100, -1, "both_dc_rd");
        expect_grant(1'b0, 28'h0000200, 1'b0, "both_ic");
        tick();
        ic_bus.req_valid = 0;
        do_read(1'b0, 128'h200, -1, "both_ic_rd");

        // Single dcache read, data 1..4, with an idle cycle before the third beat.
        dc_bus.req_valid = 1; dc_bus.req_addr = 28'h0000123; dc_bus.req_rw = 0;
        expect_grant(1'b1, 28'h0000123, 1'b0, "dc_single");
        tick();
        dc_bus.req_valid = 0;
        do_read(1'b1, 128'h1, 2, "dc_single_rd");

        // Stray response beat in IDLE is dropped and the arbiter stays ready.
        mem_bus.resp_valid = 1; mem_bus.resp_data = 128'hDEAD;
        #1;
        check("stray_ic", 128'(ic_bus.resp_valid), 128'(0));
        check("stray_dc", 128'(dc_bus.resp_valid), 128'(0));
        tick();
        mem_bus.resp_valid = 0;

        // icache write: data presented early is not forwarded until WRITE.
        ic_bus.req_valid = 1; ic_bus.req_addr = 28'h0000040; ic_bus.req_rw = 1;
        ic_bus.req_data_valid = 1; ic_bus.req_data_bits = {16{8'hA5}}; ic_bus.req_data_mask = 16'h000F;
        dc_bus.req_data_valid = 1; dc_bus.req_data_bits = {16{8'h3C}}; dc_bus.req_data_mask = 16'hFFFF;
        expect_grant(1'b0, 28'h0000040, 1'b1, "wr_req");
        check("wr_early_dvalid", 128'(mem_bus.req_data_valid), 128'(0));
        tick();
        ic_bus.req_valid = 0;
        for (int c = 0; c < 4; c++) begin
            mem_bus.req_data_ready = (c == 3);
            #1;
            check($sformatf("wr_c%0d_dvalid", c), 128'(mem_bus.req_data_valid), 128'(1));
            check($sformatf("wr_c%0d_bits", c), mem_bus.req_data_bits, {16{8'hA5}});
            check($sformatf("wr_c%0d_mask", c), 128'(mem_bus.req_data_mask), 128'(16'h000F));
            check($sformatf("wr_c%0d_ic_drdy", c), 128'(ic_bus.req_data_ready), 128'(c == 3));
            check($sformatf("wr_c%0d_dc_drdy", c), 128'(dc_bus.req_data_ready), 128'(0));
            tick();
        end
        mem_bus.req_data_ready = 1;
        #1;
        check("wr_done_dvalid", 128'(mem_bus.req_data_valid), 128'(0));
        check("wr_done_ic_drdy", 128'(ic_bus.req_data_ready), 128'(0));
        ic_bus.req_data_valid = 0; dc_bus.req_data_valid = 0; mem_bus.req_data_ready = 0;
        ic_bus.req_rw = 0;

        // Continuous contention alternates dc, ic, dc, ic, dc, ic.
        ic_bus.req_valid = 1; ic_bus.req_addr = 28'h0000010;
        dc_bus.req_valid = 1; dc_bus.req_addr = 28'h0000020;
        for (int t = 0; t < 6; t++) begin
            expect_grant((t % 2) == 0, ((t % 2) == 0) ? 28'h0000020 : 28'h0000010, 1'b0,
                         $sformatf("rr%0d", t));
            tick();
            do_read((t % 2) == 0, 128'(t * 16), -1, $sformatf("rr%0d_rd", t));
        end
        ic_bus.req_valid = 0; dc_bus.req_valid = 0;

        // Reset after the second beat of a dc read, then a fresh ic read.
        dc_bus.req_valid = 1; dc_bus.req_addr = 28'h0000055;
        expect_grant(1'b1, 28'h0000055, 1'b0, "mid_req");
        tick();
        for (int b = 0; b < 2; b++) begin
            mem_bus.resp_valid = 1; mem_bus.resp_data = 128'(b + 8);
            tick();
        end
        reset = 1;
        #1;
        check("mid_rst_dcv", 128'(dc_bus.resp_valid), 128'(0));
        check("mid_rst_dcd", dc_bus.resp_data, 128'(0));
        check("mid_rst_mvalid", 128'(mem_bus.req_valid), 128'(0));
        check("mid_rst_count", 128'(dut.count), 128'(0));
        mem_bus.resp_valid = 0; dc_bus.req_valid = 0;
        tick();
        reset = 0;
        ic_bus.req_valid = 1; ic_bus.req_addr = 28'h0000077;
        expect_grant(1'b0, 28'h0000077, 1'b0, "post_rst_ic");
        tick();
        ic_bus.req_valid = 0;
        dc_bus.req_valid = 1; dc_bus.req_addr = 28'h0000099;
        do_read(1'b0, 128'h700, -1, "post_rst_rd");
        expect_grant(1'b1, 28'h0000099, 1'b0, "post_rst_next");
        dc_bus.req_valid = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
